// File: rtl/ifu_pfq.sv
// ============================================================================
//  Module   : ifu_pfq
//  Purpose  : Instruction-fetch prefetch queue. Issues sequential fetch
//             requests under a credit limit, buffers in-order responses in a
//             DEPTH-entry {pc,inst} FIFO and presents them to decode. A
//             redirect empties the FIFO and marks every outstanding request
//             stale. Stale responses are dropped while the block is flushing.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             o_req_val/i_req_rdy/o_req_addr   fetch request channel
//             i_rsp_val/i_rsp_data             in-order response channel
//             o_val/i_rdy/o_in/o_pc            decode channel
//             i_setpc/i_pc/i_pcadd             redirect strobe and target
//             o_flushing                       stale responses pending
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_pfq #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_req_val,
  input  logic            i_req_rdy,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_rsp_val,
  input  logic [31:0]     i_rsp_data,
  output logic            o_val,
  input  logic            i_rdy,
  output logic [31:0]     o_in,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_setpc,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pcadd,
  output logic            o_flushing
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pf_pc_q,    pf_pc_d;
  logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0]   out_cnt_q,  out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   occ_q,      occ_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;

  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [31:0]     mem_inst_q [DEPTH];

  logic [CW-1:0]   w_credit;
  logic            w_req_val;
  logic            w_req_fire;
  logic            w_flush;
  logic            w_rsp_ok;
  logic            w_push;
  logic            w_val;
  logic            w_pop;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_tgt;

  // Live (non-stale) in-flight requests plus buffered entries must never
  // exceed DEPTH, which is what makes a FIFO overflow impossible.
  assign w_credit   = out_cnt_q - drop_cnt_q + occ_q;
  // Gating with rst_n keeps the request quiet while reset is held.
  assign w_req_val  = rst_n && !i_setpc && (w_credit < C_DEPTH);
  assign w_req_fire = w_req_val && i_req_rdy;
  assign w_flush    = (state_q == ST_FLUSH);
  // A response with nothing outstanding is spurious and has no effect.
  assign w_rsp_ok   = i_rsp_val && (out_cnt_q != '0);
  // A redirect discards any same-cycle response, whatever the state.
  assign w_push     = w_rsp_ok && !w_flush && !i_setpc;
  assign w_val      = (occ_q != '0);
  assign w_pop      = w_val && i_rdy;
  assign w_sum      = i_pc + i_pcadd;
  assign w_tgt      = w_sum & ~XLEN'(3);

  always_comb begin
    pf_pc_d    = pf_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (i_setpc) begin
      // No request can fire this cycle (o_req_val is low), so every
      // request still outstanding after this edge is stale.
      pf_pc_d    = w_tgt;
      rsp_pc_d   = w_tgt;
      out_cnt_d  = out_cnt_q - CW'(w_rsp_ok);
      drop_cnt_d = out_cnt_q - CW'(w_rsp_ok);
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (w_req_fire) pf_pc_d = pf_pc_q + XLEN'(4);
      if (w_push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (w_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      out_cnt_d  = out_cnt_q + CW'(w_req_fire) - CW'(w_rsp_ok);
      drop_cnt_d = drop_cnt_q - CW'(w_rsp_ok && w_flush);
      occ_d      = occ_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pf_pc_q    <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
      pf_pc_q    <= pf_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is deliberately left unreset; occ_q qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
      mem_inst_q[wr_ptr_q] <= i_rsp_data;
    end
  end

  assign o_req_val  = w_req_val;
  assign o_req_addr = pf_pc_q;
  assign o_val      = w_val;
  assign o_in       = w_val ? mem_inst_q[rd_ptr_q] : 32'h0;
  assign o_pc       = w_val ? mem_pc_q[rd_ptr_q]   : '0;
  assign o_flushing = w_flush;

endmodule

`default_nettype wire

// File: tb/tb_ifu_pfq.sv
// ============================================================================
//  Module   : tb_ifu_pfq
//  Purpose  : Self-checking bench for ifu_pfq. The bench plays the memory
//             (in-order responses, random latency) and keeps a queue-based
//             reference model of the fetch/flush behaviour. Every cycle's
//             outputs are compared with the model, plus directed checks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifu_pfq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_req_val;
  logic        i_req_rdy = 1'b0;
  logic [31:0] o_req_addr;
  logic        i_rsp_val = 1'b0;
  logic [31:0] i_rsp_data = 32'h0;
  logic        o_val;
  logic        i_rdy = 1'b0;
  logic [31:0] o_in;
  logic [31:0] o_pc;
  logic        i_setpc = 1'b0;
  logic [31:0] i_pc = 32'h0;
  logic [31:0] i_pcadd = 32'h0;
  logic        o_flushing;

  ifu_pfq #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_req_val(o_req_val), .i_req_rdy(i_req_rdy), .o_req_addr(o_req_addr),
    .i_rsp_val(i_rsp_val), .i_rsp_data(i_rsp_data),
    .o_val(o_val), .i_rdy(i_rdy), .o_in(o_in), .o_pc(o_pc),
    .i_setpc(i_setpc), .i_pc(i_pc), .i_pcadd(i_pcadd),
    .o_flushing(o_flushing)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state
  logic [31:0] m_pf, m_rsp;
  bit          m_stale [$];   // one flag per outstanding request, oldest first
  logic [63:0] m_fifo  [$];   // {pc, inst}
  logic [31:0] mem_q   [$];   // memory side: accepted addresses
  logic        e_req_val;
  logic [98:0] e_vec;
  logic        dut_fire;
  logic [31:0] dut_addr;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] f_inst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [98:0] pack_outs();
    return {o_req_val, o_req_addr, o_val, o_in, o_pc, o_flushing};
  endfunction

  task automatic model_clear(input bit clear_mem);
    m_stale.delete();
    m_fifo.delete();
    m_pf  = RESET_PC;
    m_rsp = RESET_PC;
    if (clear_mem) mem_q.delete();
  endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic do_reset(input bit clear_mem);
    i_setpc = 1'b0; i_rdy = 1'b0; i_req_rdy = 1'b0; i_rsp_val = 1'b0;
    #2;
    rst_n = 1'b0;
    model_clear(clear_mem);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Apply inputs, move to the negedge and compute the model's expectations.
  task automatic drive(input logic setpc, input logic [31:0] pc,
                       input logic [31:0] pcadd, input logic rdy,
                       input logic rrdy, input int rsp_pct, input int spur_pct);
    int ns;
    int st;
    logic [63:0] head;
    i_setpc = setpc; i_pc = pc; i_pcadd = pcadd; i_rdy = rdy; i_req_rdy = rrdy;
    if (mem_q.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
      i_rsp_val = 1'b1; i_rsp_data = f_inst(mem_q[0]);
    end else if (mem_q.size() == 0 && int'($urandom_range(99)) < spur_pct) begin
      i_rsp_val = 1'b1; i_rsp_data = $urandom;
    end else begin
      i_rsp_val = 1'b0; i_rsp_data = $urandom;
    end
    @(negedge clk);
    ns = 0; st = 0;
    foreach (m_stale[k]) if (m_stale[k]) st++; else ns++;
    e_req_val = !setpc && ((ns + m_fifo.size()) < DEPTH);
    head = (m_fifo.size() != 0) ? m_fifo[0] : 64'h0;
    e_vec = {e_req_val, m_pf, m_fifo.size() != 0, head[31:0], head[63:32], st > 0};
    dut_fire = o_req_val & i_req_rdy;
    dut_addr = o_req_addr;
  endtask

  // Cross the active edge and apply the spec's rules to the model.
  task automatic advance();
    logic [31:0] t;
    bit          s;
    @(posedge clk);
    t = (i_pc + i_pcadd) & ~32'h3;
    if (m_fifo.size() != 0 && i_rdy) void'(m_fifo.pop_front());
    if (i_rsp_val && m_stale.size() != 0) begin
      s = m_stale.pop_front();
      if (!s && !i_setpc) begin
        m_fifo.push_back({m_rsp, f_inst(m_rsp)});
        m_rsp += 32'd4;
      end
    end
    if (e_req_val && i_req_rdy) begin
      m_stale.push_back(1'b0);
      m_pf += 32'd4;
    end
    if (i_setpc) begin
      foreach (m_stale[k]) m_stale[k] = 1'b1;
      m_fifo.delete();
      m_pf  = t;
      m_rsp = t;
    end
    if (i_rsp_val && mem_q.size() != 0) void'(mem_q.pop_front());
    if (dut_fire) mem_q.push_back(dut_addr);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (i == 0) begin
        n_checks++;
        if ({o_req_val, o_req_addr} !== {1'b1, RESET_PC}) begin
          n_fail++; $display("FAIL first_req got=%b/%h exp=1/%h", o_req_val, o_req_addr, RESET_PC);
        end
      end
      advance();
    end
    // Asynchronous assertion: outputs must clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pack_outs() !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_outs got=%h exp=%h", pack_outs(),
                         {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0});
    end
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Spurious response with nothing outstanding must be ignored.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 100);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL spurious_rsp cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      advance();
    end
  endtask

  task automatic test_stream();
    logic [31:0] nxt;
    nxt = RESET_PC;
    do_reset(1'b1);
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (i >= 2) begin
        n_checks++;
        if ({o_val, o_pc, o_in} !== {1'b1, nxt, f_inst(nxt)}) begin
          n_fail++; $display("FAIL stream_nobubble i=%0d got=%b/%h/%h exp=1/%h/%h",
                             i, o_val, o_pc, o_in, nxt, f_inst(nxt));
        end
        nxt += 32'd4;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int fires;
    fires = 0;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (o_req_val && i_req_rdy) fires++;
      advance();
    end
    n_checks++;
    if (fires != DEPTH) begin
      n_fail++; $display("FAIL bp_fires got=%0d exp=%0d", fires, DEPTH);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 100, 0);
    n_checks++;
    if ({o_req_val, o_val, o_pc} !== {1'b0, 1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL bp_full got=%b/%b/%h exp=0/1/%h", o_req_val, o_val, o_pc, RESET_PC);
    end
    advance();
  endtask

  task automatic test_redirect();
    bit got_first;
    got_first = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 0, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL redirect_pre cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      advance();
    end
    drive(1'b1, 32'h8000_1000, 32'h6, 1'b1, 1'b1, 0, 0);
    n_checks++;
    if (pack_outs() !== e_vec) begin
      n_fail++; $display("FAIL redirect_set cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
    end
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL redirect_run cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (i == 0) begin
        n_checks++;
        if ({o_req_val, o_req_addr, o_flushing} !== {1'b1, 32'h8000_1004, 1'b1}) begin
          n_fail++; $display("FAIL redirect_addr got=%b/%h/%b exp=1/80001004/1",
                             o_req_val, o_req_addr, o_flushing);
        end
      end
      if (o_val && !got_first) begin
        got_first = 1'b1;
        n_checks++;
        if (o_pc !== 32'h8000_1004) begin
          n_fail++; $display("FAIL redirect_first_pc got=%h exp=80001004", o_pc);
        end
      end
      advance();
    end
    n_checks++;
    if (!got_first) begin
      n_fail++; $display("FAIL redirect_timeout got=no_output exp=output");
    end
  endtask

  task automatic test_collision();
    bit got_first;
    got_first = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, (i < 2) ? 100 : 0, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL collide_pre cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      advance();
    end
    // Redirect, response and decode handshake all in one cycle.
    drive(1'b1, 32'h8000_2000, 32'h0, 1'b1, 1'b1, 100, 0);
    n_checks++;
    if (pack_outs() !== e_vec) begin
      n_fail++; $display("FAIL collide_set cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
    end
    n_checks++;
    if ({i_rsp_val, o_val, o_pc} !== {1'b1, 1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL collide_consume got=%b/%b/%h exp=1/1/%h", i_rsp_val, o_val, o_pc, RESET_PC);
    end
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, (i == 0) ? 0 : 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL collide_run cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (i == 0) begin
        n_checks++;
        if ({o_flushing, o_val} !== 2'b10) begin
          n_fail++; $display("FAIL collide_flush got=%b/%b exp=1/0", o_flushing, o_val);
        end
      end
      if (o_val && !got_first) begin
        got_first = 1'b1;
        n_checks++;
        if (o_pc !== 32'h8000_2000) begin
          n_fail++; $display("FAIL collide_first_pc got=%h exp=80002000", o_pc);
        end
      end
      advance();
    end
    n_checks++;
    if (!got_first) begin
      n_fail++; $display("FAIL collide_timeout got=no_output exp=output");
    end
  endtask

  task automatic test_double_redirect();
    bit got_any;
    got_any = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        3:       drive(1'b1, 32'h8000_3000, 32'h0,  1'b0, 1'b1, 0, 0);
        4:       drive(1'b1, 32'h8000_4000, 32'h10, 1'b0, 1'b1, 0, 0);
        default: drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0);
      endcase
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL dbl_pre cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      advance();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL dbl_run cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (o_val) begin
        got_any = 1'b1;
        n_checks++;
        if (o_pc < 32'h8000_4010 || o_pc >= 32'h8000_4110) begin
          n_fail++; $display("FAIL dbl_target got=%h exp=80004010..8000410c", o_pc);
        end
      end
      advance();
    end
    n_checks++;
    if (!got_any) begin
      n_fail++; $display("FAIL dbl_timeout got=no_output exp=output");
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1'b1, 32'hFFFF_FFF0, 32'hD, 1'b1, 1'b1, 0, 0);
      else        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (o_req_addr !== ((i == 1) ? 32'hFFFF_FFFC : 32'h0)) begin
          n_fail++; $display("FAIL wrap_addr i=%0d got=%h exp=%h", i, o_req_addr,
                             (i == 1) ? 32'hFFFF_FFFC : 32'h0);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midop();
    bit got_first;
    got_first = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0);
      advance();
    end
    // Memory keeps its pending responses across the reset.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, (i >= 6), 100, 0);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL reset_midop cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      if (o_val && !got_first) begin
        got_first = 1'b1;
        n_checks++;
        if (o_pc !== RESET_PC) begin
          n_fail++; $display("FAIL midop_first_pc got=%h exp=%h", o_pc, RESET_PC);
        end
      end
      advance();
    end
    n_checks++;
    if (!got_first) begin
      n_fail++; $display("FAIL midop_timeout got=no_output exp=output");
    end
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 4, $urandom, $urandom,
            $urandom_range(99) < 55, $urandom_range(99) < 70, 60, 10);
      n_checks++;
      if (pack_outs() !== e_vec) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, pack_outs(), e_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_collision();
    test_double_redirect();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
